// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: operation classes, operations
// (including branch and RV32M codes) and the serial mul/div FSM states.
package ex_stage_pkg;

  localparam int ALUSEL_W = 4;
  localparam int ALUOP_W  = 6;

  typedef enum logic [ALUSEL_W-1:0] {
    SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH, SEL_COMPARE,
    SEL_JUMP, SEL_BRANCH, SEL_LOAD, SEL_STORE, EXE_MULDIV
  } alusel_e;

  typedef enum logic [ALUOP_W-1:0] {
    OP_NOP,
    OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA,
    OP_ADD, OP_SUB,
    OP_SLT, OP_SLTU,
    OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } aluop_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input aluop_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Serial RV32M unit: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, with sign correction applied when the result is latched.
module ex_muldiv
  import ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start,
  input  logic [ALUOP_W-1:0] i_op,
  input  logic [XLEN-1:0]    i_a,
  input  logic [XLEN-1:0]    i_b,
  input  logic               i_stall_mem,
  output logic               o_stall,
  output logic               o_done,
  output logic [XLEN-1:0]    o_result
);

  localparam int CNT_W = $clog2(MD_ITERS) + 1;

  md_state_e             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_opnd;
  logic [XLEN-1:0]       r_result;
  aluop_e                r_op;
  logic                  r_is_div;
  logic                  r_neg_q;
  logic                  r_neg_r;

  aluop_e                w_op;
  logic                  w_a_signed;
  logic                  w_b_signed;
  logic                  w_sa;
  logic                  w_sb;
  logic [XLEN-1:0]       w_abs_a;
  logic [XLEN-1:0]       w_abs_b;
  logic                  w_is_div;
  logic                  w_div0;
  logic                  w_ovf;
  logic [XLEN-1:0]       w_special;
  logic [XLEN:0]         w_mul_sum;
  logic [XLEN:0]         w_rem_sh;
  logic [XLEN:0]         w_diff;
  logic [2*XLEN-1:0]     w_next;

  function automatic logic [XLEN-1:0] md_finalize(input aluop_e op,
                                                  input logic [2*XLEN-1:0] acc,
                                                  input logic neg_q,
                                                  input logic neg_r);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = quo;
      default:                      res = rem;
    endcase
    return res;
  endfunction

  assign w_op       = aluop_e'(i_op);
  assign w_a_signed = w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign w_b_signed = w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign w_sa       = w_a_signed & i_a[XLEN-1];
  assign w_sb       = w_b_signed & i_b[XLEN-1];
  assign w_abs_a    = w_sa ? -i_a : i_a;
  assign w_abs_b    = w_sb ? -i_b : i_b;
  assign w_is_div   = md_is_div(w_op);
  assign w_div0     = w_is_div & (i_b == '0);
  assign w_ovf      = (w_op inside {OP_DIV, OP_REM}) &
                      (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == '1);

  always_comb begin
    w_special = '0;
    if (w_div0)
      w_special = (w_op inside {OP_DIV, OP_DIVU}) ? '1 : i_a;
    else if (w_op == OP_DIV)
      w_special = {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply: acc = {partial high, multiplier shifting out}; divide: acc = {remainder, dividend/quotient}.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_next    = !r_is_div ? {w_mul_sum, r_acc[XLEN-1:1]} :
                     w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                                    {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_op     <= OP_NOP;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_cnt    <= '0;
            r_op     <= w_op;
            r_is_div <= w_is_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
            if (w_div0 | w_ovf) begin
              r_result <= w_special;
              r_state  <= MD_DONE;
            end else begin
              r_state  <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          r_acc <= w_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MD_ITERS-1)) begin
            r_result <= md_finalize(r_op, w_next, r_neg_q, r_neg_r);
            r_state  <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (!i_stall_mem)
            r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Stall covers the issue cycle too, so it must see the start request combinationally.
  assign o_stall  = reset & (((r_state == MD_IDLE) & i_start) | (r_state == MD_BUSY));
  assign o_done   = (r_state == MD_DONE);
  assign o_result = r_result;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, address generation and branch resolution,
// plus the serial mul/div unit whose busy time stalls the front of the pipe.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall_mem,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [XLEN-1:0]     op1_i,
  input  logic [XLEN-1:0]     op2_i,
  input  logic [XLEN-1:0]     link_addr_i,
  input  logic                write_i,
  input  logic [4:0]          regw_addr_i,
  input  logic [XLEN-1:0]     mem_offset_i,
  input  logic [XLEN-1:0]     br_addr_i,
  input  logic [XLEN-1:0]     br_offset_i,
  input  logic                prediction_i,
  input  logic                no_prediction_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                stall_req_o,
  output logic                discard_o,
  output logic [XLEN-1:0]     br_target_o,
  output logic                bp_update_o,
  output logic [XLEN-1:0]     bp_pc_o,
  output logic                bp_taken_o,
  output logic                write_o,
  output logic [4:0]          regw_addr_o,
  output logic [XLEN-1:0]     wdata_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o
);

  localparam int SH_W = $clog2(XLEN);

  alusel_e             w_sel;
  aluop_e              w_op;
  logic [SH_W-1:0]     w_shamt;
  logic                w_eq;
  logic                w_lt;
  logic                w_ltu;
  logic                w_cmp;
  logic                w_branch;
  logic                w_mem;
  logic                w_taken;
  logic [XLEN-1:0]     w_tgt_sum;
  logic [XLEN-1:0]     w_taken_tgt;
  logic [XLEN-1:0]     w_wdata;
  logic                w_md_start;
  logic                w_md_stall;
  logic                w_md_done;
  logic [XLEN-1:0]     w_md_result;

  assign w_sel    = alusel_e'(alusel_i);
  assign w_op     = aluop_e'(aluop_i);
  assign w_shamt  = op2_i[SH_W-1:0];
  assign w_eq     = (op1_i == op2_i);
  assign w_lt     = ($signed(op1_i) < $signed(op2_i));
  assign w_ltu    = (op1_i < op2_i);
  assign w_branch = (w_sel == SEL_JUMP) | (w_sel == SEL_BRANCH);
  assign w_mem    = (w_sel == SEL_LOAD) | (w_sel == SEL_STORE);

  always_comb begin
    w_cmp = 1'b0;
    case (w_op)
      OP_BEQ:  w_cmp = w_eq;
      OP_BNE:  w_cmp = !w_eq;
      OP_BLT:  w_cmp = w_lt;
      OP_BGE:  w_cmp = !w_lt;
      OP_BLTU: w_cmp = w_ltu;
      OP_BGEU: w_cmp = !w_ltu;
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_taken     = (w_sel == SEL_JUMP) | ((w_sel == SEL_BRANCH) & w_cmp);
  assign w_tgt_sum   = br_addr_i + br_offset_i;
  assign w_taken_tgt = (w_op == OP_JALR) ? {w_tgt_sum[XLEN-1:1], 1'b0} : w_tgt_sum;

  // Gating with stall_mem keeps a held branch from flushing or training twice.
  assign br_target_o = !w_branch ? '0 : (w_taken ? w_taken_tgt : pc_i + XLEN'(4));
  assign discard_o   = w_branch & (no_prediction_i | (w_taken != prediction_i)) & !stall_mem;
  assign bp_update_o = w_branch & !stall_mem;
  assign bp_pc_o     = pc_i;
  assign bp_taken_o  = w_taken;

  always_comb begin
    w_wdata = '0;
    case (w_sel)
      SEL_LOGIC: begin
        case (w_op)
          OP_AND:  w_wdata = op1_i & op2_i;
          OP_OR:   w_wdata = op1_i | op2_i;
          OP_XOR:  w_wdata = op1_i ^ op2_i;
          default: w_wdata = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (w_op)
          OP_SLL:  w_wdata = op1_i << w_shamt;
          OP_SRL:  w_wdata = op1_i >> w_shamt;
          OP_SRA:  w_wdata = $signed(op1_i) >>> w_shamt;
          default: w_wdata = '0;
        endcase
      end
      SEL_ARITH: begin
        case (w_op)
          OP_ADD:  w_wdata = op1_i + op2_i;
          OP_SUB:  w_wdata = op1_i - op2_i;
          default: w_wdata = '0;
        endcase
      end
      SEL_COMPARE: begin
        case (w_op)
          OP_SLT:  w_wdata = {{(XLEN-1){1'b0}}, w_lt};
          OP_SLTU: w_wdata = {{(XLEN-1){1'b0}}, w_ltu};
          default: w_wdata = '0;
        endcase
      end
      SEL_JUMP:   w_wdata = link_addr_i;
      EXE_MULDIV: w_wdata = w_md_done ? w_md_result : '0;
      default:    w_wdata = '0;
    endcase
  end

  assign w_md_start = (w_sel == EXE_MULDIV);

  ex_muldiv #(
    .XLEN     (XLEN),
    .MD_ITERS (MD_ITERS)
  ) u_muldiv (
    .clock       (clock),
    .reset       (reset),
    .i_start     (w_md_start),
    .i_op        (aluop_i),
    .i_a         (op1_i),
    .i_b         (op2_i),
    .i_stall_mem (stall_mem),
    .o_stall     (w_md_stall),
    .o_done      (w_md_done),
    .o_result    (w_md_result)
  );

  assign stall_req_o = w_md_stall;
  assign wdata_o     = w_wdata;
  assign write_o     = write_i;
  assign regw_addr_o = regw_addr_i;
  assign aluop_o     = aluop_i;
  assign mem_addr_o  = w_mem ? op1_i + mem_offset_i : '0;
  assign mem_wdata_o = w_mem ? op2_i : '0;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a plain-arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall_mem;
  logic [3:0]  alusel_i;
  logic [5:0]  aluop_i;
  logic [31:0] op1_i, op2_i, link_addr_i, mem_offset_i, br_addr_i, br_offset_i, pc_i;
  logic        write_i, prediction_i, no_prediction_i;
  logic [4:0]  regw_addr_i;
  logic        stall_req_o, discard_o, bp_update_o, bp_taken_o, write_o;
  logic [31:0] br_target_o, bp_pc_o, wdata_o, mem_addr_o, mem_wdata_o;
  logic [4:0]  regw_addr_o;
  logic [5:0]  aluop_o;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock(clock), .reset(reset), .stall_mem(stall_mem),
    .alusel_i(alusel_i), .aluop_i(aluop_i), .op1_i(op1_i), .op2_i(op2_i),
    .link_addr_i(link_addr_i), .write_i(write_i), .regw_addr_i(regw_addr_i),
    .mem_offset_i(mem_offset_i), .br_addr_i(br_addr_i), .br_offset_i(br_offset_i),
    .prediction_i(prediction_i), .no_prediction_i(no_prediction_i), .pc_i(pc_i),
    .stall_req_o(stall_req_o), .discard_o(discard_o), .br_target_o(br_target_o),
    .bp_update_o(bp_update_o), .bp_pc_o(bp_pc_o), .bp_taken_o(bp_taken_o),
    .write_o(write_o), .regw_addr_o(regw_addr_o), .wdata_o(wdata_o),
    .aluop_o(aluop_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_nop();
    stall_mem = 0; alusel_i = '0; aluop_i = '0; op1_i = '0; op2_i = '0;
    link_addr_i = '0; write_i = 0; regw_addr_i = '0; mem_offset_i = '0;
    br_addr_i = '0; br_offset_i = '0; prediction_i = 0; no_prediction_i = 0; pc_i = '0;
  endtask

  function automatic logic [3:0] class_of(input aluop_e op);
    if (op inside {OP_AND, OP_OR, OP_XOR}) return SEL_LOGIC;
    if (op inside {OP_SLL, OP_SRL, OP_SRA}) return SEL_SHIFT;
    if (op inside {OP_ADD, OP_SUB}) return SEL_ARITH;
    if (op inside {OP_SLT, OP_SLTU}) return SEL_COMPARE;
    if (op inside {OP_JAL, OP_JALR}) return SEL_JUMP;
    if (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) return SEL_BRANCH;
    if (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}) return SEL_LOAD;
    if (op inside {OP_SB, OP_SH, OP_SW}) return SEL_STORE;
    if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU})
      return EXE_MULDIV;
    return SEL_NOP;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference for all single-cycle outputs, derived from the current inputs.
  task automatic check_comb(input string tag);
    aluop_e      op;
    int          sa, sb;
    logic [63:0] ext;
    logic [31:0] e_w, e_addr, e_wd, e_tgt;
    bit          br, mem, taken;
    op = aluop_e'(aluop_i);
    sa = op1_i; sb = op2_i;
    br  = op inside {OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    mem = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    case (op)
      OP_BEQ:  taken = (op1_i == op2_i);
      OP_BNE:  taken = (op1_i != op2_i);
      OP_BLT:  taken = (sa < sb);
      OP_BGE:  taken = (sa >= sb);
      OP_BLTU: taken = (op1_i < op2_i);
      OP_BGEU: taken = (op1_i >= op2_i);
      OP_JAL, OP_JALR: taken = 1;
      default: taken = 0;
    endcase
    ext = {{32{op1_i[31]}}, op1_i};
    case (op)
      OP_AND:  e_w = op1_i & op2_i;
      OP_OR:   e_w = op1_i | op2_i;
      OP_XOR:  e_w = op1_i ^ op2_i;
      OP_SLL:  e_w = op1_i << op2_i[4:0];
      OP_SRL:  e_w = op1_i >> op2_i[4:0];
      OP_SRA:  e_w = 32'(ext >> op2_i[4:0]);
      OP_ADD:  e_w = op1_i + op2_i;
      OP_SUB:  e_w = op1_i - op2_i;
      OP_SLT:  e_w = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e_w = (op1_i < op2_i) ? 32'd1 : 32'd0;
      OP_JAL, OP_JALR: e_w = link_addr_i;
      default: e_w = 32'd0;
    endcase
    e_addr = mem ? op1_i + mem_offset_i : 32'd0;
    e_wd   = mem ? op2_i : 32'd0;
    if (!br)        e_tgt = 32'd0;
    else if (taken) e_tgt = (br_addr_i + br_offset_i) & ((op == OP_JALR) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
    else            e_tgt = pc_i + 32'd4;
    check_eq({tag, ".wdata"},  wdata_o, e_w);
    check_eq({tag, ".maddr"},  mem_addr_o, e_addr);
    check_eq({tag, ".mwdata"}, mem_wdata_o, e_wd);
    check_eq({tag, ".target"}, br_target_o, e_tgt);
    check_eq({tag, ".discard"}, 32'(discard_o),
             32'(br && (no_prediction_i || (taken != prediction_i)) && !stall_mem));
    check_eq({tag, ".bpupd"},  32'(bp_update_o), 32'(br && !stall_mem));
    check_eq({tag, ".bptaken"}, 32'(bp_taken_o), 32'(taken));
    check_eq({tag, ".bppc"},   bp_pc_o, pc_i);
    check_eq({tag, ".stall"},  32'(stall_req_o), 32'd0);
    check_eq({tag, ".write"},  32'(write_o), 32'(write_i));
    check_eq({tag, ".regw"},   32'(regw_addr_o), 32'(regw_addr_i));
    check_eq({tag, ".aluop"},  32'(aluop_o), 32'(aluop_i));
  endtask

  function automatic bit md_special(input aluop_e op, input logic [31:0] a, input logic [31:0] b);
    if (!(op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})) return 0;
    if (b == 32'd0) return 1;
    return (op inside {OP_DIV, OP_REM}) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] md_model(input aluop_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int ia, ib;
    ea = (op inside {OP_MUL, OP_MULH, OP_MULHSU}) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op inside {OP_MUL, OP_MULH}) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    ia = a; ib = b;
    case (op)
      OP_MUL:                       return p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
      OP_DIV:  if (b == 0) return 32'hFFFFFFFF;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
               else return 32'(ia / ib);
      OP_REM:  if (b == 0) return a;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
               else return 32'(ia % ib);
      OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one mul/div, count stall cycles, check result, optionally hold DONE.
  task automatic run_md(input string tag, input aluop_e op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int n;
    exp = md_model(op, a, b);
    stall_mem = 0; alusel_i = EXE_MULDIV; aluop_i = op; op1_i = a; op2_i = b;
    #1;
    n = 0;
    while (stall_req_o === 1'b1 && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    check_eq({tag, ".lat"}, 32'(n), md_special(op, a, b) ? 32'd1 : 32'd33);
    check_eq({tag, ".res"}, wdata_o, exp);
    if (hold > 0) begin
      stall_mem = 1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        check_eq({tag, ".hold_stall"}, 32'(stall_req_o), 32'd0);
        check_eq({tag, ".hold_res"}, wdata_o, exp);
      end
      stall_mem = 0;
    end
    @(posedge clock); #1;
    drive_nop();
    #1;
    check_eq({tag, ".idle_stall"}, 32'(stall_req_o), 32'd0);
    check_eq({tag, ".idle_w"}, wdata_o, 32'd0);
  endtask

  aluop_e comb_ops[20] = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB,
                           OP_SLT, OP_SLTU, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT,
                           OP_BGE, OP_BLTU, OP_BGEU, OP_LW, OP_SW};
  aluop_e md_ops[8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  initial begin
    aluop_e op;
    drive_nop();
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    alusel_i = EXE_MULDIV; aluop_i = OP_DIV; op1_i = 32'd9; op2_i = 32'd3;
    #1;
    check_eq("rst.stall", 32'(stall_req_o), 32'd0);
    check_eq("rst.wdata", wdata_o, 32'd0);
    drive_nop();
    @(posedge clock); #1;
    reset = 1;
    #1;
    check_eq("nop.stall", 32'(stall_req_o), 32'd0);
    check_comb("nop");
    check_eq("nop.target", br_target_o, 32'd0);

    @(negedge clock);
    alusel_i = SEL_ARITH; aluop_i = OP_ADD; op1_i = 32'h7FFFFFFF; op2_i = 32'd1; #1;
    check_eq("add_ovf", wdata_o, 32'h80000000);
    check_comb("add_ovf");
    alusel_i = SEL_SHIFT; aluop_i = OP_SRA; op1_i = 32'h80000000; op2_i = 32'd4; #1;
    check_eq("sra", wdata_o, 32'hF8000000);

    drive_nop();
    alusel_i = SEL_BRANCH; aluop_i = OP_BEQ; op1_i = 32'd5; op2_i = 32'd5;
    pc_i = 32'h100; br_addr_i = 32'h100; br_offset_i = 32'h20; #1;
    check_eq("beq.discard", 32'(discard_o), 32'd1);
    check_eq("beq.target", br_target_o, 32'h120);
    check_eq("beq.taken", 32'(bp_taken_o), 32'd1);
    check_eq("beq.upd", 32'(bp_update_o), 32'd1);
    stall_mem = 1; #1;
    check_eq("beq_stall.discard", 32'(discard_o), 32'd0);
    check_eq("beq_stall.upd", 32'(bp_update_o), 32'd0);
    drive_nop();

    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      op = comb_ops[$urandom_range(0, 19)];
      alusel_i = class_of(op); aluop_i = op;
      op1_i = rnd_val();
      op2_i = ($urandom_range(0, 3) == 0) ? op1_i : rnd_val();
      link_addr_i = $urandom; mem_offset_i = $urandom; pc_i = $urandom;
      br_addr_i = $urandom; br_offset_i = $urandom;
      prediction_i = 1'($urandom_range(0, 1)); no_prediction_i = ($urandom_range(0, 3) == 0);
      stall_mem = ($urandom_range(0, 3) == 0);
      write_i = 1'($urandom_range(0, 1)); regw_addr_i = 5'($urandom);
      #1;
      check_comb("rnd");
    end
    drive_nop();
    @(posedge clock); #1;

    run_md("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_md("mulh", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_md("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
    run_md("rem_neg", OP_REM, 32'hFFFFFFF9, 32'd2, 3);
    run_md("divu_0", OP_DIVU, 32'h12345678, 32'd0, 0);
    run_md("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    run_md("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 1);
    for (int i = 0; i < 10; i++) begin
      op = md_ops[$urandom_range(0, 7)];
      run_md("md_rnd", op, rnd_val(), ($urandom_range(0, 4) == 0) ? 32'd0 : rnd_val(),
             int'($urandom_range(0, 2)));
    end

    alusel_i = EXE_MULDIV; aluop_i = OP_DIV; op1_i = 32'd100; op2_i = 32'd7;
    repeat (10) @(posedge clock);
    #1;
    check_eq("busy.stall", 32'(stall_req_o), 32'd1);
    reset = 0;
    #1;
    check_eq("abort.stall", 32'(stall_req_o), 32'd0);
    check_eq("abort.wdata", wdata_o, 32'd0);
    drive_nop();
    @(posedge clock); #1;
    reset = 1;
    #1;
    run_md("div_after_rst", OP_DIV, 32'd100, 32'd7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage between the ID/EX pipeline register and the EX/MEM pipeline register.
- Computes ALU results, load/store addresses and store data.
- Resolves branches and jumps against the IF prediction, and issues flush and redirect plus predictor-update signals.
- Runs RV32M multiply/divide on a 32-iteration serial unit and holds the pipeline with a stall request while it is busy.

Parameters:
- XLEN, 32, datapath width.
- MD_ITERS, 32, serial mul/div iterations (must equal XLEN).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall_mem  in  1  downstream hold; EX/MEM is not accepting this cycle.
- alusel_i  in  `AluSelBus  operation class from ID/EX.
- aluop_i  in  `AluOpBus  operation from ID/EX.
- op1_i, op2_i  in  32  operands.
- link_addr_i  in  32  pc+4 for JAL/JALR.
- write_i  in  1  register write enable.
- regw_addr_i  in  5  destination register.
- mem_offset_i  in  32  load/store immediate.
- br_addr_i, br_offset_i  in  32  branch base and offset.
- prediction_i  in  1  IF predicted taken.
- no_prediction_i  in  1  target unknown at IF (JALR); always redirect.
- pc_i  in  32  instruction PC.
- stall_req_o  out  1  hold IF..EX (drives stall[3]).
- discard_o  out  1  flush IF/ID and ID/EX.
- br_target_o  out  32  redirect PC.
- bp_update_o  out  1  predictor update strobe.
- bp_pc_o  out  32  PC of the resolved branch.
- bp_taken_o  out  1  actual branch outcome.
- write_o  out  1  register write enable to EX/MEM.
- regw_addr_o  out  5  destination register to EX/MEM.
- wdata_o  out  32  result to EX/MEM.
- aluop_o  out  `AluOpBus  operation to EX/MEM.
- mem_addr_o  out  32  load/store address.
- mem_wdata_o  out  32  store data.

Behaviour:
- Reset (reset=0, async): FSM goes to IDLE; iteration counter, accumulators and done flag clear; stall_req_o=0.
- Combinational outputs follow inputs. With an all-zero NOP from ID/EX, every output is 0.
- Non-MULDIV classes are zero-latency combinational:
  - LOGIC/SHIFT/ARITH/COMPARE on op1_i and op2_i; shift amount = op2_i[4:0]; SRA sign-fills.
  - JUMP: wdata_o=link_addr_i.
  - LOAD/STORE: mem_addr_o=op1_i+mem_offset_i (wraps mod 2^32); mem_wdata_o=op2_i.
- Branch resolution:
  - taken = compare result for BEQ/BNE/BLT/BGE/BLTU/BGEU; 1 for JAL/JALR.
  - br_target_o = taken ? br_addr_i+br_offset_i : pc_i+4. For JALR, bit 0 of the target is cleared.
  - discard_o = branch_class & (no_prediction_i | taken!=prediction_i) & !stall_mem.
  - bp_update_o = branch_class & !stall_mem; bp_pc_o=pc_i; bp_taken_o=taken.
  - Masking with stall_mem guarantees exactly one flush and one predictor update per branch.
- MULDIV FSM (IDLE, BUSY, DONE):
  - IDLE, MULDIV present: load operands (absolute values for signed ops, sign flags saved), counter=0, go to BUSY; stall_req_o=1.
  - Special divides skip to DONE after one cycle:
    - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
    - DIV/REM 0x80000000 / -1: quotient=0x80000000, remainder=0.
  - BUSY: one shift-add (mul, 64-bit product) or restoring-subtract (div) step per cycle. stall_req_o=1. At counter==MD_ITERS-1, go to DONE.
  - DONE: apply sign correction. Result muxed to wdata_o: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder (remainder takes the dividend's sign). stall_req_o=0.
  - DONE persists while stall_mem=1. Go to IDLE on the first cycle with stall_mem=0, when the instruction advances.
  - Latency: general ops issue at cycle 0, stall_req_o=1 for cycles 0..32, result in cycle 33. Special divides: stall 1 cycle, result in cycle 1.
  - A MULDIV arriving in the cycle DONE leaves is a new instruction and starts IDLE->BUSY the next cycle.
  - Async reset mid-BUSY aborts and returns to IDLE; stall_req_o=0 immediately.
- stall_req_o is never asserted for non-MULDIV classes.

Decomposition:
- Shared definitions file (define.v) additions:
  - AluSel code EXE_MULDIV.
  - AluOp codes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Branch-op codes and FSM state encodings.
- One sub-module, ex_muldiv: serial mul/div unit with FSM, a start/done interface and special-case handling.
- ex_stage holds the ALU, branch resolution and output muxing.

Test Plan:
- ADD 0x7FFFFFFF+1 -> wdata_o=0x80000000 same cycle, stall_req_o=0. SRA 0x80000000 by 4 -> 0xF8000000.
- BEQ op1=op2=5, prediction_i=0, pc=0x100, br_addr=0x100, offset=0x20 -> discard_o=1, br_target_o=0x120, bp_taken_o=1. Repeat with stall_mem=1 -> discard_o=0, bp_update_o=0.
- MUL 0xFFFFFFFF*0xFFFFFFFF (MULHU) -> stall_req_o high 33 cycles, then wdata_o=0xFFFFFFFE. MULH of the same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF after 1 stall cycle. DIV 0x80000000/-1 -> 0x80000000.
- DONE with stall_mem=1 for 3 cycles -> wdata_o stable and stall_req_o=0 throughout; IDLE after release.
- Assert reset at BUSY cycle 10 -> stall_req_o=0 immediately. The next DIV after reset runs the full 33-cycle latency with the correct result.
